coherence_bus_arbiter: RTL

Arbiter and sequencer for the shared snooping bus between the two MSI cache controllers. It grants the bus to one cache at a time with round-robin fairness, broadcasts the winning bus transaction to the other cache, and samples the snoop response. It then either completes the fill cache-to-cache or issues a memory read and waits a fixed latency. It sits between the two `cache_directlyMapped_32x37bits` instances and the read side of `memory512x32bits`, replacing the point-to-point `bus_reply` wiring.

---
 rtl/coherence_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/coherence_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared MSI snoop bus; fills from the snooping cache or memory.
// Latency: gnt +1, done +3 (upgrade/c2c) or +3+MEM_LAT; no backpressure, owner holds req until done and dropping it aborts.
module coherence_bus_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              snoop_found,
  input  logic [DATA_W-1:0] snoop_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_src,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, GRANT, SNOOP, MEM, DONE} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
  } txn_t;

  localparam logic [1:0] OP_UPGR = 2'b11;

  state_t            state, state_nxt;
  txn_t              txn;
  logic              owner;
  logic              ptr;
  logic [3:0]        cnt;
  logic              pick;
  logic              abort;
  logic              is_upgr;
  logic              mem_last;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;

  assign pick     = (req == 2'b11) ? ptr : req[1];
  assign sel_op   = pick ? op1 : op0;
  assign sel_addr = pick ? addr1 : addr0;
  assign abort    = ~req[owner];
  assign is_upgr  = (txn.op == OP_UPGR);
  assign mem_last = (cnt == 4'(MEM_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    bus_op    = 2'b00;
    bus_addr  = '0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    done      = 2'b00;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (req != 2'b00) state_nxt = GRANT;
      GRANT: state_nxt = abort ? IDLE : SNOOP;
      SNOOP: begin
        if (abort)                         state_nxt = IDLE;
        else if (is_upgr || snoop_found)   state_nxt = DONE;
        else                               state_nxt = MEM;
      end
      MEM: begin
        if (cnt == 4'd0) begin
          mem_rd   = 1'b1;
          mem_addr = txn.addr;
        end
        if (abort)         state_nxt = IDLE;
        else if (mem_last) state_nxt = DONE;
      end
      DONE: begin
        done[owner] = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      gnt[owner] = 1'b1;
      bus_op     = txn.op;
      bus_addr   = txn.addr;
    end
  end

  // Op 00 is latched as an upgrade so the bus never shows the idle code mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      ptr       <= 1'b0;
      txn       <= '0;
      cnt       <= 4'd0;
      fill_data <= '0;
      fill_src  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner    <= pick;
            txn.op   <= (sel_op == 2'b00) ? OP_UPGR : sel_op;
            txn.addr <= sel_addr;
          end
        end
        GRANT: if (abort) ptr <= ~owner;
        SNOOP: begin
          if (abort) begin
            ptr <= ~owner;
          end else if (is_upgr) begin
            fill_src <= 1'b0;
          end else if (snoop_found) begin
            fill_data <= snoop_data;
            fill_src  <= 1'b1;
          end
        end
        MEM: begin
          if (abort) begin
            ptr <= ~owner;
            cnt <= 4'd0;
          end else if (mem_last) begin
            fill_data <= mem_rdata;
            fill_src  <= 1'b0;
            cnt       <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: ptr <= ~owner;
        default: ;
      endcase
    end
  end

endmodule
